// File: rtl/overlay_mixer_if.sv
// Pixel-stream bundle between the emblem overlay front end and overlay_mixer:
// background/overlay colours with syncs in, mixed colour with delayed syncs out.
interface overlay_mixer_if;
  logic       active_in;
  logic       hsync_in;
  logic       vsync_in;
  logic       x_lsb;
  logic       y_lsb;
  logic [5:0] bg_rgb;
  logic [5:0] ov_rgb;
  logic [5:0] rgb_out;
  logic       hsync_out;
  logic       vsync_out;

  modport master (
    output active_in, hsync_in, vsync_in, x_lsb, y_lsb, bg_rgb, ov_rgb,
    input  rgb_out, hsync_out, vsync_out
  );

  modport slave (
    input  active_in, hsync_in, vsync_in, x_lsb, y_lsb, bg_rgb, ov_rgb,
    output rgb_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/overlay_mixer.sv
// Alpha-blends the 6-bit overlay over the background with a per-frame fade FSM.
// Optional OVERLAY_MIXER_DITHER_EN adds a 2x2 Bayer rounding bias to the blend.
module overlay_mixer #(
  parameter logic [5:0]  KEY_COLOR       = 6'b100001,
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  show,
  overlay_mixer_if.slave        pix,
  output logic [2:0]            alpha,
  output logic                  fade_busy
);

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  localparam logic [3:0] LAST_FRAME = 4'(FRAMES_PER_STEP - 1);

  state_t     state_r;
  state_t     state_n_s;
  logic [2:0] alpha_r;
  logic [2:0] alpha_n_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_n_s;
  logic [3:0] cnt_base_s;
  logic       fade_busy_r;
  logic       fade_busy_n_s;
  logic       step_en_s;
  logic       step_up_s;
  logic       restart_s;
  logic [1:0] bias_s;
  logic [1:0] ch_r_s;
  logic [1:0] ch_g_s;
  logic [1:0] ch_b_s;
  logic [5:0] mix_s;
  logic [5:0] rgb_r;
  logic       hsync_r;
  logic       vsync_r;

  function automatic logic [1:0] mix_chan(input logic [1:0] ov, input logic [1:0] bg,
                                          input logic [2:0] a, input logic [1:0] bias);
    logic [3:0] sum;
    sum = ({2'b00, ov} * {1'b0, a}) + ({2'b00, bg} * (4'd4 - {1'b0, a})) + {2'b00, bias};
    return sum[3:2];
  endfunction

  // Fade state, alpha and frame counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HIDDEN;
      alpha_r     <= 3'd0;
      cnt_r       <= 4'd0;
      fade_busy_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      alpha_r     <= alpha_n_s;
      cnt_r       <= cnt_n_s;
      fade_busy_r <= fade_busy_n_s;
    end
  end

  // Decode the fade direction requested by this frame_start
  always_comb begin
    step_en_s = 1'b0;
    step_up_s = 1'b0;
    restart_s = 1'b0;
    if (frame_start) begin
      case (state_r)
        HIDDEN:   begin step_en_s = show;  step_up_s = 1'b1; restart_s = 1'b1;  end
        FADE_IN:  begin step_en_s = 1'b1;  step_up_s = show; restart_s = ~show; end
        SHOWN:    begin step_en_s = ~show; step_up_s = 1'b0; restart_s = 1'b1;  end
        FADE_OUT: begin step_en_s = 1'b1;  step_up_s = show; restart_s = show;  end
        default:  begin step_en_s = 1'b0;  step_up_s = 1'b0; restart_s = 1'b0;  end
      endcase
    end else begin
      step_en_s = 1'b0;
    end
  end

  // Next state: the pulse that starts (or reverses) a fade counts as its first frame
  always_comb begin
    state_n_s  = state_r;
    alpha_n_s  = alpha_r;
    cnt_n_s    = cnt_r;
    cnt_base_s = restart_s ? 4'd0 : cnt_r;
    if (!step_en_s) begin
      state_n_s = state_r;
    end else if (step_up_s && (alpha_r == 3'd4)) begin
      state_n_s = SHOWN;
      cnt_n_s   = 4'd0;
    end else if (!step_up_s && (alpha_r == 3'd0)) begin
      state_n_s = HIDDEN;
      cnt_n_s   = 4'd0;
    end else begin
      if (cnt_base_s == LAST_FRAME) begin
        alpha_n_s = step_up_s ? (alpha_r + 3'd1) : (alpha_r - 3'd1);
        cnt_n_s   = 4'd0;
      end else begin
        cnt_n_s   = cnt_base_s + 4'd1;
      end
      if (step_up_s) begin
        state_n_s = (alpha_n_s == 3'd4) ? SHOWN : FADE_IN;
      end else begin
        state_n_s = (alpha_n_s == 3'd0) ? HIDDEN : FADE_OUT;
      end
    end
  end

  // Busy flag follows the state being entered
  always_comb begin
    case (state_n_s)
      FADE_IN:  fade_busy_n_s = 1'b1;
      FADE_OUT: fade_busy_n_s = 1'b1;
      default:  fade_busy_n_s = 1'b0;
    endcase
  end

`ifdef OVERLAY_MIXER_DITHER_EN
  // Bayer 2x2 rounding bias indexed by {y_lsb, x_lsb}
  always_comb begin
    case ({pix.y_lsb, pix.x_lsb})
      2'b00:   bias_s = 2'd0;
      2'b01:   bias_s = 2'd2;
      2'b10:   bias_s = 2'd3;
      2'b11:   bias_s = 2'd1;
      default: bias_s = 2'd0;
    endcase
  end
`else
  logic unused_dither_s;
  assign bias_s          = 2'd0;
  assign unused_dither_s = pix.x_lsb ^ pix.y_lsb;
`endif

  // Pixel blend; channel c occupies bits {c+3, c}
  always_comb begin
    ch_r_s = mix_chan({pix.ov_rgb[5], pix.ov_rgb[2]}, {pix.bg_rgb[5], pix.bg_rgb[2]}, alpha_r, bias_s);
    ch_g_s = mix_chan({pix.ov_rgb[4], pix.ov_rgb[1]}, {pix.bg_rgb[4], pix.bg_rgb[1]}, alpha_r, bias_s);
    ch_b_s = mix_chan({pix.ov_rgb[3], pix.ov_rgb[0]}, {pix.bg_rgb[3], pix.bg_rgb[0]}, alpha_r, bias_s);
    if (!pix.active_in) begin
      mix_s = 6'd0;
    end else if (pix.ov_rgb == KEY_COLOR) begin
      mix_s = pix.bg_rgb;
    end else begin
      mix_s = {ch_r_s[1], ch_g_s[1], ch_b_s[1], ch_r_s[0], ch_g_s[0], ch_b_s[0]};
    end
  end

  // Output pixel and sync registers share one stage of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r   <= 6'd0;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else begin
      rgb_r   <= mix_s;
      hsync_r <= pix.hsync_in;
      vsync_r <= pix.vsync_in;
    end
  end

  assign pix.rgb_out   = rgb_r;
  assign pix.hsync_out = hsync_r;
  assign pix.vsync_out = vsync_r;
  assign alpha         = alpha_r;
  assign fade_busy     = fade_busy_r;

endmodule

// File: tb/tb_overlay_mixer.sv
// Scoreboard bench for overlay_mixer: directed fade scenarios plus random traffic
// checked against a frame-level fade model and integer blend arithmetic.
module tb_overlay_mixer;
  localparam int         FPS = 4;
  localparam logic [5:0] KEY = 6'b100001;

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic [2:0] a;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       show;
  logic [2:0] alpha;
  logic       fade_busy;

  overlay_mixer_if pix ();

  overlay_mixer #(.KEY_COLOR(KEY), .FRAMES_PER_STEP(FPS)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .show(show),
    .pix(pix), .alpha(alpha), .fade_busy(fade_busy)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   m_alpha;
  int   m_frames;
  int   m_dir;
  logic held_show;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [5:0] model_pix(input logic act, input logic [5:0] bg, input logic [5:0] ov,
                                           input logic x, input logic y, input int a);
    int bayer[4] = '{0, 2, 3, 1};
    int bias;
    logic [5:0] r;
    if (!act) return 6'd0;
    if (ov == KEY) return bg;
`ifdef OVERLAY_MIXER_DITHER_EN
    bias = bayer[{30'd0, y, x}];
`else
    bias = 0;
`endif
    for (int c = 0; c < 3; c++) begin
      int o, b, v;
      o = ov[c + 3] * 2 + ov[c];
      b = bg[c + 3] * 2 + bg[c];
      v = (o * a + b * (4 - a) + bias) / 4;
      r[c + 3] = v[1];
      r[c]     = v[0];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_alpha  = 0;
    m_frames = 0;
    m_dir    = 0;
  endtask

  // Frame-level fade model: dir is +1/-1 while fading, 0 when settled
  task automatic model_frame(input logic sh);
    int want;
    want = sh ? 1 : -1;
    if ((want == 1 && m_alpha == 4) || (want == -1 && m_alpha == 0)) begin
      m_dir    = 0;
      m_frames = 0;
    end else begin
      if (want != m_dir) m_frames = 0;
      m_dir = want;
      m_frames++;
      if (m_frames == FPS) begin
        m_alpha += m_dir;
        m_frames = 0;
        if (m_alpha == 0 || m_alpha == 4) m_dir = 0;
      end
    end
  endtask

  task automatic drive(input logic fs, input logic sh, input logic act, input logic hs, input logic vs,
                       input logic x, input logic y, input logic [5:0] bg, input logic [5:0] ov);
    exp_t e;
    @(negedge clk);
    frame_start = fs; show = sh;
    pix.active_in = act; pix.hsync_in = hs; pix.vsync_in = vs;
    pix.x_lsb = x; pix.y_lsb = y; pix.bg_rgb = bg; pix.ov_rgb = ov;
    e.rgb = model_pix(act, bg, ov, x, y, m_alpha);
    e.hs  = hs;
    e.vs  = vs;
    if (fs) model_frame(sh);
    e.a    = 3'(m_alpha);
    e.busy = (m_dir != 0);
    exp_q.push_back(e);
  endtask

  task automatic rnd_pix(input logic fs, input logic sh);
    logic [5:0] ov;
    ov = ($urandom_range(0, 3) == 0) ? KEY : 6'($urandom);
    drive(fs, sh, ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 6'($urandom), ov);
  endtask

  task automatic settle_chk(input string name, input int act_sel, input int req);
    @(posedge clk); #2;
    case (act_sel)
      0:       chk(name, alpha, req);
      1:       chk(name, fade_busy, req);
      2:       chk(name, pix.rgb_out, req);
      3:       chk(name, pix.hsync_out, req);
      default: chk(name, pix.vsync_out, req);
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rgb", pix.rgb_out, 0);
    chk("rst_alpha", alpha, 0);
    chk("rst_busy", fade_busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      frame_start = 1'($urandom); show = 1'($urandom);
      pix.active_in = 1'b1; pix.hsync_in = 1'($urandom); pix.vsync_in = 1'b0;
      pix.bg_rgb = 6'($urandom); pix.ov_rgb = 6'b111111;
      @(posedge clk); #2;
      chk("rst_rgb_hold", pix.rgb_out, 0);
      chk("rst_hsync", pix.hsync_out, 1);
      chk("rst_vsync", pix.vsync_out, 1);
      chk("rst_alpha_hold", alpha, 0);
    end
    @(negedge clk);
    frame_start = 1'b0; show = 1'b0;
    pix.active_in = 1'b0; pix.hsync_in = 1'b1; pix.vsync_in = 1'b1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic pulses(input int n, input logic sh, input int chk_every, input int first_alpha, input int dir);
    for (int p = 1; p <= n; p++) begin
      rnd_pix(1'b1, sh);
      if (chk_every != 0 && (p % chk_every) == 0)
        settle_chk("alpha_step", 0, first_alpha + dir * (p / chk_every - 1));
      rnd_pix(1'b0, 1'($urandom));
      rnd_pix(1'b0, 1'($urandom));
    end
  endtask

  // Scoreboard monitor: one expected entry per driven pixel cycle
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_rgb", pix.rgb_out, mon_e.rgb);
      chk("sb_hsync", pix.hsync_out, mon_e.hs);
      chk("sb_vsync", pix.vsync_out, mon_e.vs);
      chk("sb_alpha", alpha, mon_e.a);
      chk("sb_busy", fade_busy, mon_e.busy);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; show = 1'b0;
    pix.active_in = 1'b0; pix.hsync_in = 1'b1; pix.vsync_in = 1'b1;
    pix.x_lsb = 1'b0; pix.y_lsb = 1'b0; pix.bg_rgb = 6'd0; pix.ov_rgb = 6'd0;
    model_reset();
    held_show = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Full fade-in: alpha 1,2,3,4 after pulses 4,8,12,16
    pulses(16, 1'b1, 4, 1, 1);
    settle_chk("shown_busy", 1, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b110110);
    settle_chk("shown_ov", 2, 6'b110110);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b010101, KEY);
    settle_chk("shown_key", 2, 6'b010101);

    // Half-way blend at alpha=2, then reversal
    do_reset();
    pulses(8, 1'b1, 4, 1, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b111111);
    settle_chk("mix_yx00", 2, 6'b000111);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b000000, 6'b111111);
    settle_chk("mix_yx11", 2, 6'b000111);
`ifdef OVERLAY_MIXER_DITHER_EN
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 6'b111111);
    settle_chk("mix_yx01", 2, 6'b111000);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, 6'b111111);
    settle_chk("mix_yx10", 2, 6'b111000);
`else
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 6'b111111);
    settle_chk("mix_yx01", 2, 6'b000111);
`endif
    pulses(8, 1'b0, 4, 1, -1);
    settle_chk("rev_busy_drop", 1, 0);

    // Blanking and sync pass-through
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b101010, 6'b111111);
    settle_chk("blank_rgb", 2, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000);
    settle_chk("hsync_delay", 3, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000);
    settle_chk("vsync_delay", 4, 0);

    // Reset in the middle of a fade, then hidden frames stay hidden
    pulses(6, 1'b1, 0, 0, 0);
    do_reset();
    pulses(5, 1'b0, 0, 0, 0);
    settle_chk("post_rst_alpha", 0, 0);

    // Random traffic with occasional show changes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) held_show = ~held_show;
      rnd_pix(($urandom_range(0, 5) == 0), held_show);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
